// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned,
// with start/busy/done handshake and registered, held results.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] Rn,
   input  logic [WIDTH-1:0] Rm,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   rem_acc;
   logic [WIDTH-1:0] quo_acc;
   logic [WIDTH-1:0] dvsr;
   logic             neg_q;
   logic             neg_r;
   logic             zero_div;

   logic [WIDTH-1:0] abs_n;
   logic [WIDTH-1:0] abs_m;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   always_comb begin
      abs_n   = (signed_op && Rn[WIDTH-1]) ? -Rn : Rn;
      abs_m   = (signed_op && Rm[WIDTH-1]) ? -Rm : Rm;
      shifted = {rem_acc[WIDTH-1:0], quo_acc[WIDTH-1]};
      trial   = shifted - {1'b0, dvsr};
   end

   // busy/done are registered views of the state, so they lag it by one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         rem_acc     <= '0;
         quo_acc     <= '0;
         dvsr        <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         zero_div    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         busy <= (state == BUSY);
         done <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  div_by_zero <= 1'b0;
                  rem_acc     <= '0;
                  dvsr        <= abs_m;
                  neg_q       <= signed_op && (Rn[WIDTH-1] ^ Rm[WIDTH-1]);
                  neg_r       <= signed_op && Rn[WIDTH-1];
                  zero_div    <= (Rm == '0);
                  if (Rm == '0) begin
                     // keep the raw dividend: it is returned untouched as the remainder
                     quo_acc <= Rn;
                     state   <= DONE;
                  end else begin
                     quo_acc <= abs_n;
                     count   <= CW'(WIDTH);
                     state   <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (!trial[WIDTH]) begin
                  rem_acc <= trial;
                  quo_acc <= {quo_acc[WIDTH-2:0], 1'b1};
               end else begin
                  rem_acc <= shifted;
                  quo_acc <= {quo_acc[WIDTH-2:0], 1'b0};
               end
               count <= count - CW'(1);
               if (count == CW'(1)) state <= DONE;
            end
            DONE: begin
               if (zero_div) begin
                  quotient  <= '0;
                  remainder <= quo_acc;
               end else begin
                  quotient  <= neg_q ? -quo_acc : quo_acc;
                  remainder <= neg_r ? -rem_acc[WIDTH-1:0] : rem_acc[WIDTH-1:0];
               end
               div_by_zero <= zero_div;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results come from a magnitude/sign
// reference model and are queued at issue, popped when done pulses.
module tb_seq_divider;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        signed_op;
   logic [31:0] Rn;
   logic [31:0] Rm;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   seq_divider #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
      .Rn(Rn), .Rm(Rm), .busy(busy), .done(done), .quotient(quotient),
      .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic s);
      exp_t e;
      logic [31:0] ma, mb, mq, mr;
      if (b == 32'd0) begin
         e.q = 32'd0; e.r = a; e.dz = 1'b1;
         return e;
      end
      ma = (s && a[31]) ? 32'd0 - a : a;
      mb = (s && b[31]) ? 32'd0 - b : b;
      mq = ma / mb;
      mr = ma % mb;
      e.q  = (s && (a[31] ^ b[31])) ? 32'd0 - mq : mq;
      e.r  = (s && a[31]) ? 32'd0 - mr : mr;
      e.dz = 1'b0;
      return e;
   endfunction

   // Drives one start edge, queues the expected result, then scrambles operands.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
      Rn = a; Rm = b; signed_op = s; start = 1'b1;
      sb.push_back(model(a, b, s));
      @(posedge clk); #1;
      start = 1'b0; Rn = $urandom; Rm = $urandom; signed_op = $urandom_range(0, 1);
   endtask

   // Waits (bounded) for done; lat = -1 on timeout.
   task automatic wait_done(output int lat, output int busy_cyc, output int overlap);
      lat = -1; busy_cyc = 0; overlap = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (busy) busy_cyc++;
         if (busy && done) overlap++;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; Rn = 32'd77; Rm = 32'd5; signed_op = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
         $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b, want all 0",
                  busy, done, quotient, remainder, div_by_zero);
      end else passed++;
      rst_n = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         $display("FAIL reset_no_queue: got busy=%b done=%b, want 0 0", busy, done);
      end else passed++;
   endtask

   task automatic run_list(input string tag, input logic [31:0] a[6], input logic [31:0] b[6],
                           input logic s);
      int lat, bc, ov;
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         issue(a[i], b[i], s);
         wait_done(lat, bc, ov);
         e = sb.pop_front();
         total++;
         if (lat != 33 || bc != 32 || ov != 0) begin
            $display("FAIL %s_timing[%0d]: got latency=%0d busy_cycles=%0d overlap=%0d, want 33 32 0",
                     tag, i, lat, bc, ov);
         end else passed++;
         total++;
         if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
            $display("FAIL %s_result[%0d] %h/%h: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                     tag, i, a[i], b[i], quotient, remainder, div_by_zero, e.q, e.r, e.dz);
         end else passed++;
      end
   endtask

   task automatic test_unsigned();
      logic [31:0] a[6], b[6];
      a = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, $urandom, $urandom};
      b = '{32'd7, 32'd1, 32'd9, 32'hFFFF_FFFF, $urandom_range(1, 1000), $urandom | 32'd1};
      run_list("unsigned", a, b, 1'b0);
   endtask

   task automatic test_signed();
      logic [31:0] a[6], b[6];
      a = '{32'hFFFF_FF9C, 32'd100, 32'h8000_0000, 32'hFFFF_FFF9, $urandom, $urandom};
      b = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFE, $urandom | 32'd1, 32'hFFFF_FFFD};
      run_list("signed", a, b, 1'b1);
   endtask

   task automatic test_div_zero();
      int lat, bc, ov;
      exp_t e;
      issue(32'h1234_5678, 32'd0, 1'b1);
      wait_done(lat, bc, ov);
      e = sb.pop_front();
      total++;
      if (lat != 1 || bc != 0) begin
         $display("FAIL dz_timing: got latency=%0d busy_cycles=%0d, want 1 0", lat, bc);
      end else passed++;
      total++;
      if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
         $display("FAIL dz_result: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                  quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end else passed++;
      issue(32'd9, 32'd3, 1'b0);
      total++;
      if (div_by_zero !== 1'b0) begin
         $display("FAIL dz_clear_on_start: got dz=%b, want 0", div_by_zero);
      end else passed++;
      wait_done(lat, bc, ov);
      e = sb.pop_front();
      total++;
      if (lat != 33 || {quotient, div_by_zero} !== {e.q, e.dz}) begin
         $display("FAIL dz_followup: got latency=%0d q=%h dz=%b, want 33 q=%h dz=%b",
                  lat, quotient, div_by_zero, e.q, e.dz);
      end else passed++;
   endtask

   task automatic test_ignore_start();
      int dones = 0, first = -1;
      exp_t e;
      logic [31:0] q_s = '0, r_s = '0;
      issue(32'd50, 32'd5, 1'b0);
      for (int n = 1; n <= 45; n++) begin
         if (n == 10) begin
            start = 1'b1; Rn = 32'd9; Rm = 32'd2; signed_op = 1'b0;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            dones++;
            if (first < 0) begin first = n; q_s = quotient; r_s = remainder; end
         end
      end
      e = sb.pop_front();
      total++;
      if (dones != 1 || first != 33) begin
         $display("FAIL ignore_start_pulses: got dones=%0d first_at=%0d, want 1 at 33", dones, first);
      end else passed++;
      total++;
      if ({q_s, r_s} !== {e.q, e.r}) begin
         $display("FAIL ignore_start_result: got q=%h r=%h, want q=%h r=%h", q_s, r_s, e.q, e.r);
      end else passed++;
   endtask

   task automatic test_reset_abort();
      int lat, bc, ov, dones = 0;
      exp_t e;
      issue(32'd1000, 32'd3, 1'b0);
      void'(sb.pop_front());
      repeat (14) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
         $display("FAIL abort_state: got busy=%b done=%b q=%h r=%h dz=%b, want all 0",
                  busy, done, quotient, remainder, div_by_zero);
      end else passed++;
      rst_n = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (done || busy) dones++;
      end
      total++;
      if (dones != 0) begin
         $display("FAIL abort_no_done: got %0d active cycles, want 0", dones);
      end else passed++;
      issue(32'd1000, 32'd3, 1'b0);
      wait_done(lat, bc, ov);
      e = sb.pop_front();
      total++;
      if (lat != 33 || {quotient, remainder} !== {e.q, e.r}) begin
         $display("FAIL abort_rerun: got latency=%0d q=%h r=%h, want 33 q=%h r=%h",
                  lat, quotient, remainder, e.q, e.r);
      end else passed++;
   endtask

   task automatic test_back_to_back();
      int at[$];
      exp_t e;
      Rn = 32'hFFFF_FC18; Rm = 32'd7; signed_op = 1'b1; start = 1'b1;
      sb.push_back(model(Rn, Rm, signed_op));
      sb.push_back(model(Rn, Rm, signed_op));
      for (int n = 0; n < 80 && at.size() < 2; n++) begin
         @(posedge clk); #1;
         if (done) begin
            at.push_back(n);
            e = sb.pop_front();
            total++;
            if ({quotient, remainder} !== {e.q, e.r}) begin
               $display("FAIL b2b_result[%0d]: got q=%h r=%h, want q=%h r=%h",
                        at.size(), quotient, remainder, e.q, e.r);
            end else passed++;
            if (at.size() == 2) start = 1'b0;
         end
      end
      start = 1'b0;
      total++;
      if (at.size() != 2 || at[0] != 33 || at[1] != 67) begin
         $display("FAIL b2b_spacing: got %0d dones (first=%0d last=%0d), want 2 at 33 and 67",
                  at.size(), (at.size() > 0) ? at[0] : -1, (at.size() > 1) ? at[1] : -1);
      end else passed++;
      repeat (40) @(posedge clk);
      #1;
   endtask

   initial begin
      start = 1'b0; signed_op = 1'b0; Rn = '0; Rm = '0; rst_n = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative 32-bit integer divider for the execute stage, performing the inverse operation of the single-cycle combinational multiplier. It computes quotient and remainder of a dividend by a divisor, one quotient bit per cycle, with a start/busy/done handshake so the pipeline can stall while a division is in flight. It supports both unsigned and signed (two's-complement) operation.

## Interface
- WIDTH, 32, operand and result width; the cycle counter is sized as clog2(WIDTH)+1 bits.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request a division; sampled only in IDLE.
- signed_op  in  1  1 = signed division, 0 = unsigned; captured with start.
- Rn  in  WIDTH  dividend; captured with start.
- Rm  in  WIDTH  divisor; captured with start.
- busy  out  1  high while a division is in progress (state BUSY).
- done  out  1  one-cycle pulse when results become valid.
- quotient  out  WIDTH  quotient; held until the next accepted start.
- remainder  out  WIDTH  remainder; held until the next accepted start.
- div_by_zero  out  1  set with done when the divisor is 0; held with the results.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if start=1, latch the operands and signed_op.
  - Divisor == 0: go to DONE.
  - Otherwise: go to BUSY with count=WIDTH.
  - If start=0, stay in IDLE.
- Operand prep, done at capture: when signed_op=1, take absolute values of Rn and Rm and record neg_q = Rn[31]^Rm[31] and neg_r = Rn[31].
- Unsigned magnitude 0x80000000 is valid after abs, since the datapath is unsigned.
- BUSY: restoring division, one bit per cycle.
  - partial remainder R (WIDTH+1 bits) = {R, Q[MSB]} shifted left by 1.
  - Subtract the divisor. If the result is non-negative, keep it and shift 1 into Q; otherwise restore and shift 0.
  - Decrement count. When count reaches 1, go to DONE.
- DONE:
  - Apply signs: quotient = neg_q ? -Q : Q; remainder = neg_r ? -R : R.
  - done=1 for this cycle only, then return to IDLE.
- Divide by zero: quotient=0, remainder=Rn unmodified, div_by_zero=1.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 as the natural result of the algorithm. It is not flagged.
- Results are truncated toward zero. The remainder sign follows the dividend.
- start while BUSY or DONE is ignored and is not queued.
- Operand inputs may change freely after the start cycle.
- div_by_zero clears when the next start is accepted.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, count=0.
  - Reset takes priority over start.
- Reset asserted mid-division aborts it. No done is produced, and the results read 0 the cycle after.
- Latency for a nonzero divisor, with start sampled at edge E0:
  - busy=1 for the cycles following edges E1..EWIDTH (32 cycles).
  - done=1 and results valid following edge E(WIDTH+1), i.e. 33 cycles after start.
- Divide by zero: done=1 following edge E1 (1-cycle latency). busy never asserts.
- busy and done are never high together.
- Back-to-back operation: start held high during the DONE cycle is ignored. A new start is accepted in the IDLE cycle that follows, so the minimum issue interval is 34 cycles.
- quotient, remainder and div_by_zero are registered. They change only in the DONE cycle or on reset.

## Test plan
- Unsigned 100 / 7 (signed_op=0) -> done 33 cycles after start; quotient=14, remainder=2, div_by_zero=0; busy high for exactly 32 cycles.
- Signed -100 / 7 (Rn=0xFFFFFF9C) -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Signed 100 / -7 -> quotient=-14, remainder=2.
- Divisor 0 with Rn=0x12345678 -> done 1 cycle after start; quotient=0, remainder=0x12345678, div_by_zero=1. A following 9/3 -> quotient=3, div_by_zero=0.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
- Start 50/5, then pulse start with 9/2 at cycle 10 -> second request ignored; result quotient=10, remainder=0; exactly one done pulse.
- Start 1000/3, drive rst_n=0 at cycle 15 -> busy=0, outputs 0, no done. After release, 1000/3 -> quotient=333, remainder=1.
